// File: rtl/adpcm_dec_unpack.sv
// IMA ADPCM decoder with byte unpacking.
// Takes bytes carrying two 4-bit codes over valid/ready. Emits one 16-bit signed sample per
// code over valid/ready.
// Optional build macro: ADPCM_DEC_BLOCK_HDR_EN adds a block-header port. The header preloads
// the predictor and step index while no byte is held.
module adpcm_dec_unpack #(
  parameter int unsigned LOW_NIBBLE_FIRST = 1,
  parameter int          PRED_RESET       = 0,
  parameter int unsigned INDEX_RESET      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_code,
  input  logic        in_code_vld,
  output logic        in_code_rdy,
`ifdef ADPCM_DEC_BLOCK_HDR_EN
  input  logic        hdr_vld,
  input  logic [15:0] hdr_pred,
  input  logic [6:0]  hdr_index,
`endif
  output logic [15:0] out_sample,
  output logic        out_sample_vld,
  input  logic        out_sample_rdy
);

  typedef enum logic [1:0] {StEmpty, StLo, StHi} state_e;

  localparam logic [14:0] StepTable [0:88] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  state_e             state_q;
  logic [7:0]         byte_q;
  logic signed [15:0] pred_q;
  logic [6:0]         index_q;

  logic               fire;
  logic               accept;
  logic               hdr_block;
  logic [3:0]         code;
  logic [14:0]        step;
  logic [17:0]        step_x;
  logic [17:0]        diff;
  logic signed [31:0] pred_ext;
  logic signed [31:0] diff_ext;
  logic signed [31:0] pred_sum;
  logic signed [15:0] pred_new;
  logic signed [7:0]  idx_adj;
  logic signed [7:0]  idx_sum;
  logic [6:0]         index_new;

  // Handshake: decode fires when a nibble is pending and the output slot is free or draining
  always_comb begin
    hdr_block = 1'b0;
`ifdef ADPCM_DEC_BLOCK_HDR_EN
    hdr_block = hdr_vld;
`endif
    fire        = (state_q != StEmpty) && (!out_sample_vld || out_sample_rdy);
    in_code_rdy = !hdr_block && ((state_q == StEmpty) || ((state_q == StHi) && fire));
    accept      = in_code_vld && in_code_rdy;
  end

  // Decode datapath: nibble select, step lookup, predictor and index update with clamping
  always_comb begin
    if ((state_q == StLo) == (LOW_NIBBLE_FIRST != 0)) code = byte_q[3:0];
    else                                              code = byte_q[7:4];

    step   = StepTable[index_q];
    step_x = {3'b000, step};
    diff   = (step_x >> 3)
           + (code[2] ? step_x        : 18'd0)
           + (code[1] ? (step_x >> 1) : 18'd0)
           + (code[0] ? (step_x >> 2) : 18'd0);

    pred_ext = {{16{pred_q[15]}}, pred_q};
    diff_ext = {14'd0, diff};
    pred_sum = code[3] ? (pred_ext - diff_ext) : (pred_ext + diff_ext);
    if (pred_sum > 32'sd32767)       pred_new = 16'sh7fff;
    else if (pred_sum < -32'sd32768) pred_new = 16'sh8000;
    else                             pred_new = pred_sum[15:0];

    unique case (code[2:0])
      3'd4:    idx_adj = 8'sd2;
      3'd5:    idx_adj = 8'sd4;
      3'd6:    idx_adj = 8'sd6;
      3'd7:    idx_adj = 8'sd8;
      default: idx_adj = -8'sd1;
    endcase
    idx_sum = $signed({1'b0, index_q}) + idx_adj;
    if (idx_sum < 8'sd0)       index_new = 7'd0;
    else if (idx_sum > 8'sd88) index_new = 7'd88;
    else                       index_new = idx_sum[6:0];
  end

  // Unpack FSM, predictor state and registered sample output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StEmpty;
      byte_q         <= 8'd0;
      pred_q         <= 16'(PRED_RESET);
      index_q        <= 7'(INDEX_RESET);
      out_sample     <= 16'd0;
      out_sample_vld <= 1'b0;
    end else begin
`ifdef ADPCM_DEC_BLOCK_HDR_EN
      if (hdr_vld && (state_q == StEmpty)) begin
        pred_q  <= hdr_pred;
        index_q <= (hdr_index > 7'd88) ? 7'd88 : hdr_index;
      end
`endif
      if (fire) begin
        out_sample     <= pred_new;
        out_sample_vld <= 1'b1;
        pred_q         <= pred_new;
        index_q        <= index_new;
      end else if (out_sample_rdy) begin
        out_sample_vld <= 1'b0;
      end

      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q <= StLo;
            byte_q  <= in_code;
          end
        end
        StLo: begin
          if (fire) state_q <= StHi;
        end
        StHi: begin
          // A byte arriving on the last fire is taken; this fire still uses the old byte
          if (fire) begin
            if (accept) begin
              state_q <= StLo;
              byte_q  <= in_code;
            end else begin
              state_q <= StEmpty;
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_adpcm_dec_unpack.sv
// Scoreboard bench for adpcm_dec_unpack: the driver pushes expected samples, the monitor pops on
// every output transfer.
module tb_adpcm_dec_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_code = 8'd0;
  logic        in_code_vld = 1'b0;
  logic        in_code_rdy;
  logic [15:0] out_sample;
  logic        out_sample_vld;
  logic        out_sample_rdy;
`ifdef ADPCM_DEC_BLOCK_HDR_EN
  logic        hdr_vld = 1'b0;
  logic [15:0] hdr_pred = 16'd0;
  logic [6:0]  hdr_index = 7'd0;
`endif

  always #5 clk = ~clk;

  adpcm_dec_unpack dut (
    .clk            (clk),
    .rst            (rst),
    .in_code        (in_code),
    .in_code_vld    (in_code_vld),
    .in_code_rdy    (in_code_rdy),
`ifdef ADPCM_DEC_BLOCK_HDR_EN
    .hdr_vld        (hdr_vld),
    .hdr_pred       (hdr_pred),
    .hdr_index      (hdr_index),
`endif
    .out_sample     (out_sample),
    .out_sample_vld (out_sample_vld),
    .out_sample_rdy (out_sample_rdy)
  );

  localparam int StepTab [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60,
    66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371,
    408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878,
    2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845,
    8630, 9493, 10442, 11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086,
    29794, 32767
  };

  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   last_out = 0;
  int   m_pred = 0;
  int   m_index = 0;
  int   rdy_mode = 0;
  logic rdy_drv = 1'b1;

  assign out_sample_rdy = rdy_drv;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference IMA decode of one code, advancing the model state
  task automatic model_nib(input logic [3:0] c, output int s);
    int step;
    int vp;
    step = StepTab[m_index];
    vp = step >> 3;
    if (c[2]) vp += step;
    if (c[1]) vp += step >> 1;
    if (c[0]) vp += step >> 2;
    if (c[3]) m_pred -= vp;
    else      m_pred += vp;
    if (m_pred > 32767)  m_pred = 32767;
    if (m_pred < -32768) m_pred = -32768;
    case (c[2:0])
      3'd4:    m_index += 2;
      3'd5:    m_index += 4;
      3'd6:    m_index += 6;
      3'd7:    m_index += 8;
      default: m_index -= 1;
    endcase
    if (m_index < 0)  m_index = 0;
    if (m_index > 88) m_index = 88;
    s = m_pred;
  endtask

  // Sink ready generator
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       rdy_drv = 1'b1;
        1:       rdy_drv = ($urandom_range(0, 3) != 0);
        default: rdy_drv = 1'b0;
      endcase
    end
  end

  // Monitor: a transfer seen at the negedge completes at the following posedge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_sample_vld && out_sample_rdy) begin
        last_out = int'($signed(out_sample));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0d expected none at %0t", last_out, $time);
        end else begin
          chk("sample", last_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit use_model);
    int  s0;
    int  s1;
    int  n;
    bit  acc;
    in_code     = b;
    in_code_vld = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      if (in_code_rdy && !rst) begin
        acc = 1'b1;
        if (use_model) begin
          model_nib(b[3:0], s0);
          model_nib(b[7:4], s1);
          exp_q.push_back(s0);
          exp_q.push_back(s1);
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_code_vld = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", b);
    end
  endtask

  task automatic do_reset(input int cycles);
    in_code_vld = 1'b0;
    rdy_mode    = 2;
    rst         = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    exp_q.delete();
    m_pred  = 0;
    m_index = 0;
  endtask

  task automatic set_rdy(input int mode);
    rdy_mode = mode;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset(2);
    @(negedge clk);
    chk("rst_vld", int'(out_sample_vld), 0);
    chk("rst_rdy", int'(in_code_rdy), 1);
    chk("rst_sample", int'(out_sample), 0);

    // 0x77 from reset: 11 then 41 on consecutive cycles
    set_rdy(0);
    exp_q.push_back(11);
    exp_q.push_back(41);
    send(8'h77, 1'b0);
    @(negedge clk);
    chk("lat_pre_vld", int'(out_sample_vld), 0);
    @(negedge clk);
    chk("lat1_vld", int'(out_sample_vld), 1);
    chk("lat1_sample", int'($signed(out_sample)), 11);
    @(negedge clk);
    chk("lat2_sample", int'($signed(out_sample)), 41);
    drain("drain_77");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_vld", int'(out_sample_vld), 0);

    // 0x08 from reset: zeros, index floor-clamped so 0x77 still gives 11, 41
    do_reset(2);
    set_rdy(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(11);
    exp_q.push_back(41);
    send(8'h08, 1'b0);
    send(8'h77, 1'b0);
    drain("drain_08");

    // Saturation both ways
    do_reset(2);
    set_rdy(0);
    for (int i = 0; i < 600; i++) send(8'h77, 1'b1);
    drain("drain_sat_hi");
    chk("sat_hi", last_out, 32767);
    for (int i = 0; i < 600; i++) send(8'hff, 1'b1);
    drain("drain_sat_lo");
    chk("sat_lo", last_out, -32768);

    // Backpressure hold: 0x77 then 0x12 with sink stalled
    do_reset(2);
    set_rdy(2);
    exp_q.push_back(11);
    exp_q.push_back(41);
    exp_q.push_back(62);
    exp_q.push_back(72);
    send(8'h77, 1'b0);
    @(posedge clk);
    #1;
    fork
      send(8'h12, 1'b0);
      begin
        repeat (6) begin
          @(negedge clk);
          chk("stall_sample", int'($signed(out_sample)), 11);
          chk("stall_vld", int'(out_sample_vld), 1);
          chk("stall_rdy", int'(in_code_rdy), 0);
        end
        rdy_mode = 0;
      end
    join
    drain("drain_stall");

    // Random traffic with random sink stalls and mid-stream resets
    do_reset(2);
    set_rdy(1);
    for (int i = 0; i < 3000; i++) begin
      if (i == 900 || i == 2100) begin
        do_reset(1 + int'($urandom_range(0, 2)));
        rdy_mode = 1;
        @(negedge clk);
        chk("midrst_vld", int'(out_sample_vld), 0);
        @(posedge clk);
        #1;
      end
      send(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain("drain_random");

`ifdef ADPCM_DEC_BLOCK_HDR_EN
    // Header load with out-of-range index clamps to 88
    do_reset(2);
    set_rdy(0);
    hdr_pred  = 16'hfc18;
    hdr_index = 7'd95;
    hdr_vld   = 1'b1;
    @(negedge clk);
    chk("hdr_rdy", int'(in_code_rdy), 0);
    @(posedge clk);
    #1;
    hdr_vld = 1'b0;
    exp_q.push_back(32767);
    exp_q.push_back(28672);
    send(8'h87, 1'b0);
    drain("drain_hdr");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
